// File: rtl/vga_pkg.sv
// Shared defaults (640x480@60) and coordinate types for the VGA raster timing block.
package vga_pkg;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  typedef logic [9:0] cnt_t;
  typedef logic [9:0] coord_x_t;
  typedef logic [8:0] coord_y_t;

  // Pin level for a raw (active-high) sync condition under the chosen polarity.
  function automatic logic sync_level(input logic raw, input logic active_low);
    return raw ^ active_low;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with visible/sync decode and look-ahead position.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned VISIBLE = 640,
  parameter int unsigned FRONT   = 16,
  parameter int unsigned SYNC    = 96,
  parameter int unsigned BACK    = 48,
  parameter int unsigned POS_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             step_next,
  output logic [POS_W-1:0] position,
  output logic [POS_W-1:0] position_next,
  output logic             at_end,
  output logic             visible,
  output logic             sync_raw
);

  localparam int unsigned TOTAL    = VISIBLE + FRONT + SYNC + BACK;
  localparam cnt_t        LAST     = cnt_t'(TOTAL - 1);
  localparam logic [10:0] VIS_END  = 11'(VISIBLE);
  localparam logic [10:0] SYNC_BEG = 11'(VISIBLE + FRONT);
  localparam logic [10:0] SYNC_END = 11'(VISIBLE + FRONT + SYNC);

  cnt_t count_r;
  cnt_t succ_s;
  cnt_t next_s;
  logic next_vis_s;

  assign at_end   = (count_r == LAST);
  assign succ_s   = at_end ? 10'd0 : (count_r + 10'd1);
  // step_next says whether the next enabled advance moves this axis at all
  assign next_s   = step_next ? succ_s : count_r;

  assign visible    = ({1'b0, count_r} < VIS_END);
  assign next_vis_s = ({1'b0, next_s} < VIS_END);
  assign sync_raw   = ({1'b0, count_r} >= SYNC_BEG) && ({1'b0, count_r} < SYNC_END);

  assign position      = visible    ? count_r[POS_W-1:0] : {POS_W{1'b0}};
  assign position_next = next_vis_s ? next_s[POS_W-1:0]  : {POS_W{1'b0}};

  // Axis position; steps only when inc is high, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 10'd0;
    end else if (inc) begin
      count_r <= succ_s;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: position/look-ahead coordinates, frame count, blanked colour and
// sync registered together so colour and sync leave the chip aligned.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE       = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT         = H_FRONT_DEF,
  parameter int unsigned H_SYNC          = H_SYNC_DEF,
  parameter int unsigned H_BACK          = H_BACK_DEF,
  parameter int unsigned V_VISIBLE       = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT         = V_FRONT_DEF,
  parameter int unsigned V_SYNC          = V_SYNC_DEF,
  parameter int unsigned V_BACK          = V_BACK_DEF,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [9:0]  position_x,
  output logic [9:0]  position_x_NEXT,
  output logic [8:0]  position_y,
  output logic [8:0]  position_y_NEXT,
  output logic [31:0] frame,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  coord_x_t    pos_x_s;
  coord_x_t    pos_x_next_s;
  coord_y_t    pos_y_s;
  coord_y_t    pos_y_next_s;
  logic        h_end_s;
  logic        v_end_s;
  logic        h_wrap_s;
  logic        h_vis_s;
  logic        v_vis_s;
  logic        hs_raw_s;
  logic        vs_raw_s;
  logic        visible_s;
  logic [31:0] frame_r;

  assign h_wrap_s  = pix_en & h_end_s;
  assign visible_s = h_vis_s & v_vis_s;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .POS_W   (10)
  ) u_h_axis (
    .clk           (clk),
    .rst           (rst),
    .inc           (pix_en),
    .step_next     (1'b1),
    .position      (pos_x_s),
    .position_next (pos_x_next_s),
    .at_end        (h_end_s),
    .visible       (h_vis_s),
    .sync_raw      (hs_raw_s)
  );

  // The vertical axis moves only on the end-of-line step, so its look-ahead follows h_end_s.
  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .POS_W   (9)
  ) u_v_axis (
    .clk           (clk),
    .rst           (rst),
    .inc           (h_wrap_s),
    .step_next     (h_end_s),
    .position      (pos_y_s),
    .position_next (pos_y_next_s),
    .at_end        (v_end_s),
    .visible       (v_vis_s),
    .sync_raw      (vs_raw_s)
  );

  assign position_x      = pos_x_s;
  assign position_x_NEXT = pos_x_next_s;
  assign position_y      = pos_y_s;
  assign position_y_NEXT = pos_y_next_s;
  assign frame           = frame_r;

  // Completed-frame count: bumps only on the single step that returns the raster to (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_r <= 32'd0;
    end else if (h_wrap_s && v_end_s) begin
      frame_r <= frame_r + 32'd1;
    end else begin
      frame_r <= frame_r;
    end
  end

  // Pin stage: blanked colour and polarity-corrected sync, one enabled cycle behind the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r  <= 4'd0;
      vga_g  <= 4'd0;
      vga_b  <= 4'd0;
      vga_hs <= sync_level(1'b0, SYNC_ACTIVE_LOW);
      vga_vs <= sync_level(1'b0, SYNC_ACTIVE_LOW);
    end else if (pix_en) begin
      vga_r  <= visible_s ? r : 4'd0;
      vga_g  <= visible_s ? g : 4'd0;
      vga_b  <= visible_s ? b : 4'd0;
      vga_hs <= sync_level(hs_raw_s, SYNC_ACTIVE_LOW);
      vga_vs <= sync_level(vs_raw_s, SYNC_ACTIVE_LOW);
    end else begin
      vga_r  <= vga_r;
      vga_g  <= vga_g;
      vga_b  <= vga_b;
      vga_hs <= vga_hs;
      vga_vs <= vga_vs;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 640x480 instance plus a tiny-raster, active-high-sync instance
// checked against an independent raster model and a pin scoreboard.
module tb_vga_timing;

  // index 0: default timing, index 1: tiny raster (24 x 13) with active-high sync
  localparam int HV [2] = '{640, 16};
  localparam int HF [2] = '{16, 2};
  localparam int HS [2] = '{96, 3};
  localparam int HB [2] = '{48, 3};
  localparam int VV [2] = '{480, 8};
  localparam int VF [2] = '{10, 1};
  localparam int VS [2] = '{2, 2};
  localparam int VB [2] = '{33, 2};
  localparam bit SAL [2] = '{1'b1, 1'b0};

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
  } pins_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b1;
  logic [3:0]  r = 4'd0;
  logic [3:0]  g = 4'd0;
  logic [3:0]  b = 4'd0;

  logic [9:0]  b_px, b_pxn, s_px, s_pxn;
  logic [8:0]  b_py, b_pyn, s_py, s_pyn;
  logic [31:0] b_fr, s_fr;
  logic [3:0]  b_vr, b_vg, b_vb, s_vr, s_vg, s_vb;
  logic        b_hs, b_vs, s_hs, s_vs;
  pins_t       b_pins, s_pins;

  assign b_pins = {b_vr, b_vg, b_vb, b_hs, b_vs};
  assign s_pins = {s_vr, s_vg, s_vb, s_hs, s_vs};

  int    mh [2];
  int    mv [2];
  int    mfr [2];
  pins_t last_pins [2];
  pins_t sbq0 [$];
  pins_t sbq1 [$];
  int    vectors = 0;
  int    fails = 0;
  int    en_since_rst = 0;
  int    hs_run = 0;
  int    vs_run = 0;

  always #5 clk = ~clk;

  vga_timing u_big (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .position_x(b_px), .position_x_NEXT(b_pxn),
    .position_y(b_py), .position_y_NEXT(b_pyn),
    .frame(b_fr), .r(r), .g(g), .b(b),
    .vga_r(b_vr), .vga_g(b_vg), .vga_b(b_vb), .vga_hs(b_hs), .vga_vs(b_vs)
  );

  vga_timing #(
    .H_VISIBLE(HV[1]), .H_FRONT(HF[1]), .H_SYNC(HS[1]), .H_BACK(HB[1]),
    .V_VISIBLE(VV[1]), .V_FRONT(VF[1]), .V_SYNC(VS[1]), .V_BACK(VB[1]),
    .SYNC_ACTIVE_LOW(1'b0)
  ) u_small (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .position_x(s_px), .position_x_NEXT(s_pxn),
    .position_y(s_py), .position_y_NEXT(s_pyn),
    .frame(s_fr), .r(r), .g(g), .b(b),
    .vga_r(s_vr), .vga_g(s_vg), .vga_b(s_vb), .vga_hs(s_hs), .vga_vs(s_vs)
  );

  function automatic int ht(input int i);
    return HV[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int vt(input int i);
    return VV[i] + VF[i] + VS[i] + VB[i];
  endfunction

  function automatic int nh(input int i);
    return (mh[i] == ht(i) - 1) ? 0 : mh[i] + 1;
  endfunction

  function automatic int nv(input int i);
    if (mh[i] != ht(i) - 1) return mv[i];
    return (mv[i] == vt(i) - 1) ? 0 : mv[i] + 1;
  endfunction

  function automatic int mapx(input int i, input int h);
    return (h < HV[i]) ? h : 0;
  endfunction

  function automatic int mapy(input int i, input int v);
    return (v < VV[i]) ? v : 0;
  endfunction

  function automatic pins_t rst_pins(input int i);
    pins_t p;
    p    = '0;
    p.hs = SAL[i];
    p.vs = SAL[i];
    return p;
  endfunction

  function automatic pins_t exp_pins(input int i);
    pins_t p;
    logic  vis;
    vis  = (mh[i] < HV[i]) && (mv[i] < VV[i]);
    p.r  = vis ? r : 4'd0;
    p.g  = vis ? g : 4'd0;
    p.b  = vis ? b : 4'd0;
    p.hs = ((mh[i] >= HV[i] + HF[i]) && (mh[i] < HV[i] + HF[i] + HS[i])) ^ SAL[i];
    p.vs = ((mv[i] >= VV[i] + VF[i]) && (mv[i] < VV[i] + VF[i] + VS[i])) ^ SAL[i];
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic [9:0] px, input logic [8:0] py,
                            input logic [9:0] pxn, input logic [8:0] pyn,
                            input logic [31:0] fr, input pins_t pins);
    string pre;
    pre = (i == 0) ? "big" : "small";
    check({pre, "_pos_x"}, 32'(px), mapx(i, mh[i]));
    check({pre, "_pos_y"}, 32'(py), mapy(i, mv[i]));
    check({pre, "_pos_x_next"}, 32'(pxn), mapx(i, nh(i)));
    check({pre, "_pos_y_next"}, 32'(pyn), mapy(i, nv(i)));
    check({pre, "_frame"}, fr, mfr[i]);
    check({pre, "_pins"}, 32'(pins), 32'(last_pins[i]));
  endtask

  task automatic check_all();
    check_inst(0, b_px, b_py, b_pxn, b_pyn, b_fr, b_pins);
    check_inst(1, s_px, s_py, s_pxn, s_pyn, s_fr, s_pins);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mh[i] = 0;
      mv[i] = 0;
      mfr[i] = 0;
      last_pins[i] = rst_pins(i);
    end
    sbq0.delete();
    sbq1.delete();
    en_since_rst = 0;
    hs_run = 0;
    vs_run = 0;
  endtask

  task automatic tick(input logic en);
    int a;
    int c;
    pix_en = en;
    r = 4'($urandom_range(0, 15));
    g = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    if (en) begin
      sbq0.push_back(exp_pins(0));
      sbq1.push_back(exp_pins(1));
    end
    @(posedge clk);
    #1;
    if (en) begin
      for (int i = 0; i < 2; i++) begin
        if (mh[i] == ht(i) - 1 && mv[i] == vt(i) - 1) mfr[i]++;
        a = nh(i);
        c = nv(i);
        mh[i] = a;
        mv[i] = c;
      end
      last_pins[0] = sbq0.pop_front();
      last_pins[1] = sbq1.pop_front();
      en_since_rst++;
      if (en_since_rst == 800) check("big_line1_xy", 32'({b_py, b_px}), 32'({9'd1, 10'd0}));
      if (en_since_rst == 311) check("small_frame_before", s_fr, 32'd0);
      if (en_since_rst == 312) check("small_frame_done", 32'({s_fr[7:0], s_px, s_py}), 32'({8'd1, 10'd0, 9'd0}));
      if (b_hs == 1'b0) hs_run++;
      else if (hs_run != 0) begin
        check("big_hs_width", hs_run, 96);
        hs_run = 0;
      end
      if (s_vs == 1'b1) vs_run++;
      else if (vs_run != 0) begin
        check("small_vs_width", vs_run, 48);
        vs_run = 0;
      end
    end
    if (mh[0] == 639) check("big_next_after_639", 32'(b_pxn), 32'd0);
    if (mh[1] == 23 && mv[1] == 12) check("small_next_at_end", 32'({s_pyn, s_pxn}), 32'd0);
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("rst_x_next", 32'(b_pxn), 32'd1);
    check("rst_big_hs_inactive", 32'(b_hs), 32'd1);
    check("rst_small_vs_inactive", 32'(s_vs), 32'd0);
    rst = 1'b0;

    // free-running with pix_en held high: several small frames, two big lines
    for (int k = 0; k < 1700; k++) tick(1'b1);

    // 1:3 enable pattern: counters and pins hold on the three idle clocks
    for (int k = 0; k < 330; k++) begin
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
      tick(1'b0);
    end

    // walk the small raster into the middle of a frame, then hit async reset
    for (int k = 0; k < 400 && !(mh[1] == 10 && mv[1] == 5); k++) tick(1'b1);
    pix_en = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("arst_big_x_next", 32'(b_pxn), 32'd1);
    check("arst_small_hs", 32'(s_hs), 32'd0);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    for (int k = 0; k < 400; k++) tick(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Raster timing generator that drives the pixel-coordinate interface consumed by the image generators: current and look-ahead (_NEXT) positions plus a frame counter.
- Takes back the 1-cycle-registered r/g/b from the image block.
- Applies blanking and delays hsync/vsync by one cycle so colour and sync leave the chip aligned.
- Sits between the top-level clocking and the VGA pins.

Parameters:
- H_VISIBLE, 640, visible pixels per line (must be ≤1024).
- H_FRONT, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BACK, 48, horizontal back porch (pixels).
- V_VISIBLE, 480, visible lines per frame (must be ≤512).
- V_FRONT, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BACK, 33, vertical back porch (lines).
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0, 0 = sync pulses drive 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- pix_en  in  1  pixel-clock enable; counters advance only on cycles with pix_en=1.
- position_x  out  10  current visible column; 0 outside the visible region.
- position_x_NEXT  out  10  value position_x takes at the next enabled advance.
- position_y  out  9  current visible row; 0 outside the visible region.
- position_y_NEXT  out  9  value position_y takes at the next enabled advance.
- frame  out  32  completed-frame counter.
- r, g, b  in  4 each  colour from the image block; already registered, so it corresponds to the current position.
- vga_r, vga_g, vga_b  out  4 each  registered, blanked colour to the pins.
- vga_hs, vga_vs  out  1 each  registered sync outputs, aligned with vga_r/g/b.

Behaviour:
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL likewise (default 525). Internal h_cnt/v_cnt are 10 bits and unsigned.
- Advance when pix_en=1:
  - h_cnt wraps H_TOTAL-1 → 0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1 → 0.
  - On the (H_TOTAL-1, V_TOTAL-1) → (0,0) step, frame increments; it wraps at 2^32.
- pix_en=0: every register holds, including the output pipeline.
- visible = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
- position_x = h_cnt when h_cnt < H_VISIBLE, else 0.
- position_y = v_cnt[8:0] when v_cnt < V_VISIBLE, else 0.
- position_*_NEXT are combinational from the counters' successor values, using the same mapping and wrap rules, so NEXT always equals what position_* shows after the next enabled advance.
- hs_raw = h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC). vs_raw uses the v_cnt analogue.
- Output stage, registered, updates on enabled cycles only:
  - vga_r/g/b <= visible ? r/g/b : 0.
  - vga_hs <= hs_raw XOR SYNC_ACTIVE_LOW; vga_vs likewise.
  - Total latency from counter state to pins is 1 enabled cycle.
- Reset (async assert, synchronous-to-clk deassert handled upstream):
  - h_cnt=0, v_cnt=0, frame=0.
  - vga_r/g/b=0; vga_hs/vga_vs at the inactive level (1 when SYNC_ACTIVE_LOW=1).
  - position_x/y = 0; position_x_NEXT=1, position_y_NEXT=0.
- Reset mid-frame: immediate return to (0,0). frame clears; no partial-frame increment.
- Simultaneous end-of-line and end-of-frame are the same event. Exactly one frame increment occurs per V_TOTAL×H_TOTAL enabled cycles.

Decomposition:
- Package vga_pkg holds the default 640x480@60 timing constants and a typedef for the 10-bit/9-bit coordinate types.
- One sub-module, vga_axis_counter, parameterised by VISIBLE/FRONT/SYNC/BACK. It provides count, wrap pulse, next_count, visible and sync_raw, and is instantiated twice: horizontal (inc = pix_en) and vertical (inc = pix_en & h_wrap).

Test Plan:
- Reset with pix_en=1 held → after 800 enabled cycles position_y=1 and position_x=0; after 420000 cycles frame=1, positions back to (0,0).
- Hsync: at h_cnt=656 the next-cycle vga_hs=0, and it stays 0 for exactly 96 enabled cycles. With SYNC_ACTIVE_LOW=0 the polarity is inverted.
- Vsync low for exactly 2 lines (1600 cycles) starting at v_cnt=490.
- Look-ahead: at every cycle position_x_NEXT(t) == position_x(t+1).
  - Spot-check h_cnt=639 → NEXT=0.
  - Spot-check (799,524) → NEXT (0,0).
- Blanking and alignment: drive r=g=b=4'hF constant.
  - vga_r = F for positions 0..639 one cycle later, 0 at h_cnt 640..799.
  - vga_r = 0 for all of lines 480..524.
- Enable/reset corners:
  - pix_en toggled 1:3 → counts advance only on enabled cycles; frame reaches 1 after 1,680,000 clocks.
  - rst asserted at (300,200) → outputs are at reset values immediately, with no clock needed.
